// File: rtl/eight_ifft_pkg.sv
// rtl/eight_ifft_pkg.sv - shared widths, twiddle ROM, FSM states and helpers for eight_ifft_seq
package eight_ifft_pkg;

  localparam int DW_DEF  = 32;
  localparam int TWF_DEF = 14;

  // Conjugate twiddles e^{+j*2*pi*m/8}, m = 0..3, Q1.14
  localparam logic signed [15:0] W0_RE = 16'sd16384;
  localparam logic signed [15:0] W0_IM = 16'sd0;
  localparam logic signed [15:0] W1_RE = 16'sd11585;
  localparam logic signed [15:0] W1_IM = 16'sd11585;
  localparam logic signed [15:0] W2_RE = 16'sd0;
  localparam logic signed [15:0] W2_IM = 16'sd16384;
  localparam logic signed [15:0] W3_RE = -16'sd11585;
  localparam logic signed [15:0] W3_IM = 16'sd11585;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic signed [15:0] tw_re(input logic [1:0] m);
    case (m)
      2'd0:    return W0_RE;
      2'd1:    return W1_RE;
      2'd2:    return W2_RE;
      default: return W3_RE;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_im(input logic [1:0] m);
    case (m)
      2'd0:    return W0_IM;
      2'd1:    return W1_IM;
      2'd2:    return W2_IM;
      default: return W3_IM;
    endcase
  endfunction

endpackage

// File: rtl/eight_ifft_seq_if.sv
// rtl/eight_ifft_seq_if.sv - bin input / sample output handshakes and status of eight_ifft_seq
interface eight_ifft_seq_if
  import eight_ifft_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [2:0]           out_idx;
  logic                 busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, busy
  );
endinterface

// File: rtl/eight_ifft_seq_bfly.sv
// rtl/eight_ifft_seq_bfly.sv - combinational radix-2 butterfly X=a+W*b, Y=a-W*b; IFFT_SCALE_EN halves outputs
module ifft_bfly
  import eight_ifft_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TWF = TWF_DEF
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [15:0]   w_re,
  input  logic signed [15:0]   w_im,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);
  localparam int PW = 2 * DW;
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (TWF - 1);

  logic signed [PW-1:0] p_re, p_im;
  logic signed [DW-1:0] t_re, t_im;

  always_comb begin
    p_re = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im) + RND;
    p_im = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re) + RND;
    t_re = DW'(p_re >>> TWF);
    t_im = DW'(p_im >>> TWF);
  end

`ifdef IFFT_SCALE_EN
  localparam logic signed [DW+1:0] ONE = {{(DW+1){1'b0}}, 1'b1};

  // Sum kept one bit wider so the halving sees the true carry
  function automatic logic signed [DW-1:0] halve(input logic signed [DW:0] v);
    logic signed [DW+1:0] e;
    e = {v[DW], v};
    return DW'((e + ONE) >>> 1);
  endfunction

  logic signed [DW:0] sx_re, sx_im, sy_re, sy_im;

  always_comb begin
    sx_re = {a_re[DW-1], a_re} + {t_re[DW-1], t_re};
    sx_im = {a_im[DW-1], a_im} + {t_im[DW-1], t_im};
    sy_re = {a_re[DW-1], a_re} - {t_re[DW-1], t_re};
    sy_im = {a_im[DW-1], a_im} - {t_im[DW-1], t_im};
    x_re  = halve(sx_re);
    x_im  = halve(sx_im);
    y_re  = halve(sy_re);
    y_im  = halve(sy_im);
  end
`else
  always_comb begin
    x_re = a_re + t_re;
    x_im = a_im + t_im;
    y_re = a_re - t_re;
    y_im = a_im - t_im;
  end
`endif

endmodule

// File: rtl/eight_ifft_seq.sv
// rtl/eight_ifft_seq.sv - sequential 8-point inverse DFT, one shared butterfly over 3 in-place stages
module eight_ifft_seq
  import eight_ifft_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TWF = TWF_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  eight_ifft_seq_if.slave io
);
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       we_in, we_bf;

  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  logic [1:0] stg, bpos, tw_m;
  logic [2:0] a_addr, b_addr;
  logic signed [DW-1:0] x_re, x_im, y_re, y_im;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    we_in        = 1'b0;
    we_bf        = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    case (state)
      LOAD: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          we_in = 1'b1;
          if (cnt == 4'd7) begin
            state_nx = COMPUTE;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      COMPUTE: begin
        io.busy = 1'b1;
        we_bf   = 1'b1;
        if (cnt == 4'd11) begin
          state_nx = UNLOAD;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      UNLOAD: begin
        io.busy      = 1'b1;
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          if (cnt == 4'd7) begin
            state_nx = LOAD;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nx = LOAD;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Decimation-in-time addressing: cnt[3:2] is the stage, cnt[1:0] the butterfly within it
  always_comb begin
    stg    = cnt[3:2];
    bpos   = cnt[1:0];
    a_addr = 3'd0;
    tw_m   = 2'd0;
    case (stg)
      2'd0: begin
        a_addr = {bpos, 1'b0};
        tw_m   = 2'd0;
      end
      2'd1: begin
        a_addr = {bpos[1], 1'b0, bpos[0]};
        tw_m   = {bpos[0], 1'b0};
      end
      default: begin
        a_addr = {1'b0, bpos};
        tw_m   = bpos;
      end
    endcase
    b_addr = a_addr | (3'b001 << stg);
  end

  ifft_bfly #(.DW(DW), .TWF(TWF)) u_bfly (
    .a_re (mem_re[a_addr]),
    .a_im (mem_im[a_addr]),
    .b_re (mem_re[b_addr]),
    .b_im (mem_im[b_addr]),
    .w_re (tw_re(tw_m)),
    .w_im (tw_im(tw_m)),
    .x_re (x_re),
    .x_im (x_im),
    .y_re (y_re),
    .y_im (y_im)
  );

  // Register file is not reset; a partial frame is simply overwritten by the next one
  always_ff @(posedge clk) begin
    if (rst_n && we_in) begin
      mem_re[bitrev3(cnt[2:0])] <= io.in_re;
      mem_im[bitrev3(cnt[2:0])] <= io.in_im;
    end else if (rst_n && we_bf) begin
      mem_re[a_addr] <= x_re;
      mem_im[a_addr] <= x_im;
      mem_re[b_addr] <= y_re;
      mem_im[b_addr] <= y_im;
    end
  end

  always_comb begin
    io.out_re  = '0;
    io.out_im  = '0;
    io.out_idx = 3'd0;
    if (state == UNLOAD) begin
      io.out_re  = mem_re[cnt[2:0]];
      io.out_im  = mem_im[cnt[2:0]];
      io.out_idx = cnt[2:0];
    end
  end

endmodule
